fetch_decode_unit: RTL and testbench

- Instruction-fetch sequencing and decode block for the 9-bit ISA core.
- Combines three functions: a D-bit program counter, a 16-entry branch-target lookup table, and a combinational opcode decoder producing datapath control signals.
- Sits between instruction ROM (consumes prog_ctr, returns mach_code) and the register-file/ALU/data-memory datapath.

---
 rtl/fetch_decode_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_decode_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_unit.sv
// ---------------------------------------------------------------------------
// fetch_decode_unit
//
// Purpose:
//   Instruction-fetch sequencing and decode for the 9-bit ISA core. Holds the
//   D-bit program counter, a 16-entry branch-target lookup table, and the
//   combinational opcode decoder that drives the datapath control strobes.
//   Sits between the instruction ROM (reads prog_ctr, returns mach_code) and
//   the register-file / ALU / data-memory datapath.
//
// Parameters:
//   D        program counter width (default 12)
//   DONE_PC  PC value at which done asserts (default 165)
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-low reset
//   mach_code    in   9   current instruction from instruction ROM
//   branch_flag  in   1   registered ALU "one" flag from datapath
//   reljump_en   in   1   relative-jump request
//   prog_ctr     out  D   current program counter
//   InstType     out  2   00 R-type, 10 I-type, 01 move-immediate
//   BranchInst   out  1   branch opcode strobe
//   MemRead      out  1   data-memory read strobe
//   MemWrite     out  1   data-memory write strobe
//   ALUSrc       out  1   ALU B-operand select (1 = register)
//   RegWrite     out  1   register-file write strobe
//   MemtoReg     out  1   write-back source select (1 = memory)
//   ALUOp        out  4   ALU command
//   done         out  1   program-complete indicator
//
// Configuration:
//   FETCH_HALT_EN  when defined, opcode 11111 halts the core: the PC freezes at
//                  the halt instruction's address and done stays high until
//                  reset. When undefined, 11111 is a NOP and no halt state
//                  exists.
// ---------------------------------------------------------------------------
module fetch_decode_unit #(
  parameter int D       = 12,
  parameter int DONE_PC = 165
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [8:0]   mach_code,
  input  logic         branch_flag,
  input  logic         reljump_en,
  output logic [D-1:0] prog_ctr,
  output logic [1:0]   InstType,
  output logic         BranchInst,
  output logic         MemRead,
  output logic         MemWrite,
  output logic         ALUSrc,
  output logic         RegWrite,
  output logic         MemtoReg,
  output logic [3:0]   ALUOp,
  output logic         done
);

  logic [4:0]   op;
  logic [7:0]   lut_val;
  logic [D-1:0] target;
  logic         absj;
  logic         halted;
  logic         halt_op;

  assign op = mach_code[8:4];

  // Opcode decoder. Ordered tests on the high opcode bits; the two special
  // encodings in the 0xxxx space must be tested before the generic R-type.
  always_comb begin
    InstType   = 2'b00;
    BranchInst = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUSrc     = 1'b1;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUOp      = 4'b0000;
    if (op == 5'b01110) begin
      // compare: updates flags only, no register write-back
      ALUOp = 4'b1110;
    end else if (op == 5'b01111) begin
      // addi: immediate operand on the ALU B input
      ALUSrc   = 1'b0;
      RegWrite = 1'b1;
    end else if (op[4] == 1'b0) begin
      ALUOp    = op[3:0];
      RegWrite = 1'b1;
    end else if (op[3] == 1'b0) begin
      // 10xxx load
      InstType = 2'b10;
      MemRead  = 1'b1;
      MemtoReg = 1'b1;
      RegWrite = 1'b1;
    end else if (op[2] == 1'b0) begin
      // 110xx movi
      InstType = 2'b01;
      RegWrite = 1'b1;
    end else if (op[1] == 1'b0) begin
      // 1110x store
      InstType = 2'b10;
      MemWrite = 1'b1;
    end else if (op[0] == 1'b0) begin
      // 11110 branch
      BranchInst = 1'b1;
    end
    // 11111 (halt / NOP) leaves every strobe at its default
  end

  // Branch-target table: entry k holds 16*k. Written out as a table so the
  // contents can be re-programmed per program without touching the PC logic.
  always_comb begin
    lut_val = 8'd0;
    case (mach_code[3:0])
      4'd0:  lut_val = 8'd0;
      4'd1:  lut_val = 8'd16;
      4'd2:  lut_val = 8'd32;
      4'd3:  lut_val = 8'd48;
      4'd4:  lut_val = 8'd64;
      4'd5:  lut_val = 8'd80;
      4'd6:  lut_val = 8'd96;
      4'd7:  lut_val = 8'd112;
      4'd8:  lut_val = 8'd128;
      4'd9:  lut_val = 8'd144;
      4'd10: lut_val = 8'd160;
      4'd11: lut_val = 8'd176;
      4'd12: lut_val = 8'd192;
      4'd13: lut_val = 8'd208;
      4'd14: lut_val = 8'd224;
      4'd15: lut_val = 8'd240;
      default: lut_val = 8'd0;
    endcase
  end

  assign target = D'(lut_val);
  assign absj   = BranchInst & branch_flag;

`ifdef FETCH_HALT_EN
  assign halt_op = (op == 5'b11111);

  // Halt latch: set by the halt opcode, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      halted <= 1'b0;
    end else if (halt_op) begin
      halted <= 1'b1;
    end
  end
`else
  assign halt_op = 1'b0;
  assign halted  = 1'b0;
`endif

  // Next-PC selection. The halt opcode itself also holds the PC so that the
  // frozen address is the halt instruction's own address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prog_ctr <= '0;
    end else if (halted || halt_op) begin
      prog_ctr <= prog_ctr;
    end else if (absj) begin
      prog_ctr <= target;
    end else if (reljump_en) begin
      prog_ctr <= prog_ctr + target;
    end else begin
      prog_ctr <= prog_ctr + D'(1);
    end
  end

  assign done = (prog_ctr == D'(DONE_PC)) | halted;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_unit
//
// Self-checking bench for fetch_decode_unit. Each applied instruction has its
// decode checked directly against a reference decoder, and its expected next
// PC / done value pushed to a scoreboard queue that is popped after the edge.
// Honours FETCH_HALT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fetch_decode_unit;

  localparam int D       = 12;
  localparam int DONE_PC = 165;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [8:0]   mach_code;
  logic         branch_flag;
  logic         reljump_en;
  logic [D-1:0] prog_ctr;
  logic [1:0]   InstType;
  logic         BranchInst;
  logic         MemRead;
  logic         MemWrite;
  logic         ALUSrc;
  logic         RegWrite;
  logic         MemtoReg;
  logic [3:0]   ALUOp;
  logic         done;

  typedef struct {
    string        tag;
    logic [D-1:0] pc;
    logic         done;
  } exp_t;

  exp_t sb[$];

  int pass_count  = 0;
  int check_count = 0;

  // reference state
  logic [D-1:0] model_pc     = '0;
  logic         model_halted = 1'b0;

  fetch_decode_unit #(.D(D), .DONE_PC(DONE_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .mach_code  (mach_code),
    .branch_flag(branch_flag),
    .reljump_en (reljump_en),
    .prog_ctr   (prog_ctr),
    .InstType   (InstType),
    .BranchInst (BranchInst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .ALUOp      (ALUOp),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {InstType, BranchInst, MemRead, MemWrite, ALUSrc, RegWrite,
  // MemtoReg, ALUOp}
  function automatic logic [11:0] ref_decode(input logic [4:0] op);
    logic [1:0] it;
    logic       br, mr, mw, src, rw, m2r;
    logic [3:0] aop;
    it = 2'b00; br = 0; mr = 0; mw = 0; src = 1; rw = 0; m2r = 0; aop = 4'b0000;
    case (op[4:3])
      2'b00, 2'b01: begin
        if (op == 5'b01110) aop = 4'b1110;
        else if (op == 5'b01111) begin src = 0; rw = 1; end
        else begin aop = op[3:0]; rw = 1; end
      end
      2'b10: begin it = 2'b10; mr = 1; m2r = 1; rw = 1; end
      default: begin
        if (op[2:1] == 2'b00 || op[2:1] == 2'b01) begin it = 2'b01; rw = 1; end
        else if (op[2:1] == 2'b10) begin it = 2'b10; mw = 1; end
        else if (op == 5'b11110) br = 1;
      end
    endcase
    return {it, br, mr, mw, src, rw, m2r, aop};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input string tag, input logic rst,
                               input logic [8:0] mc, input logic bf,
                               input logic rj);
    exp_t         e;
    logic [D-1:0] tgt;
    logic         halt_op;
    @(negedge clk);
    reset       = rst;
    mach_code   = mc;
    branch_flag = bf;
    reljump_en  = rj;
    #1;
    checkOutput({tag, "_dec"},
                32'({InstType, BranchInst, MemRead, MemWrite, ALUSrc,
                     RegWrite, MemtoReg, ALUOp}),
                32'(ref_decode(mc[8:4])));
    // reference next-PC
    tgt     = D'({mc[3:0], 4'b0000});
    halt_op = HALT_EN && (mc[8:4] == 5'b11111);
    if (!rst) begin
      model_pc     = '0;
      model_halted = 1'b0;
    end else if (model_halted) begin
      model_pc = model_pc;
    end else if (halt_op) begin
      model_halted = 1'b1;
    end else if (mc[8:4] == 5'b11110 && bf) begin
      model_pc = tgt;
    end else if (rj) begin
      model_pc = model_pc + tgt;
    end else begin
      model_pc = model_pc + 1;
    end
    e.tag  = tag;
    e.pc   = model_pc;
    e.done = (model_pc == D'(DONE_PC)) || model_halted;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkOutput({e.tag, "_pc"}, 32'(prog_ctr), 32'(e.pc));
    checkOutput({e.tag, "_done"}, 32'(done), 32'(e.done));
  endtask

  localparam logic [8:0] RTYPE = 9'b0_0010_0000;

  initial begin
    logic [8:0] rmc;
    reset       = 1'b0;
    mach_code   = 9'h000;
    branch_flag = 1'b0;
    reljump_en  = 1'b0;

    // reset with arbitrary instructions on the bus
    applyStimulus("rst0", 1'b0, 9'h1A5, 1'b1, 1'b1);
    applyStimulus("rst1", 1'b0, 9'h0F3, 1'b0, 1'b1);

    // straight-line R-type execution
    for (int i = 0; i < 3; i++) applyStimulus("rtype", 1'b1, RTYPE, 1'b0, 1'b0);

    // decode sweep
    applyStimulus("addi",  1'b1, 9'b01111_0001, 1'b0, 1'b0);
    applyStimulus("load",  1'b1, 9'b10000_0010, 1'b0, 1'b0);
    applyStimulus("movi",  1'b1, 9'b11000_0011, 1'b0, 1'b0);
    applyStimulus("store", 1'b1, 9'b11100_0000, 1'b0, 1'b0);
    applyStimulus("cmp",   1'b1, 9'b01110_0000, 1'b0, 1'b0);

    // branch not taken (PC 8 -> 9), then taken to entry 5
    applyStimulus("br_nt", 1'b1, 9'b11110_0101, 1'b0, 1'b0);
    applyStimulus("br_t",  1'b1, 9'b11110_0101, 1'b1, 1'b0);

    // relative jumps: 80 + 16 = 96, +4 -> 100, +32 -> 132
    applyStimulus("rel16", 1'b1, 9'b01111_0001, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus("inc", 1'b1, RTYPE, 1'b0, 1'b0);
    applyStimulus("rel32", 1'b1, 9'b0_0010_0010, 1'b1, 1'b1);
    // absolute branch beats relative request
    applyStimulus("abs_rel", 1'b1, 9'b11110_0011, 1'b1, 1'b1);
    // branch not taken with relative request: 48 + 112
    applyStimulus("brnt_rel", 1'b1, 9'b11110_0111, 1'b0, 1'b1);

    // random decode / PC traffic, halt opcode excluded
    for (int i = 0; i < 30; i++) begin
      rmc = 9'($urandom_range(0, 511));
      if (rmc[8:4] == 5'b11111) rmc[4] = 1'b0;
      applyStimulus("rand", 1'b1, rmc, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end

    // done at DONE_PC for exactly one cycle: 160 then +5
    applyStimulus("rst2", 1'b0, RTYPE, 1'b0, 1'b0);
    applyStimulus("rel160", 1'b1, 9'b0_0010_1010, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus("to165", 1'b1, RTYPE, 1'b0, 1'b0);

    // PC wrap: 17 x 240 = 4080, then increments through 4095 -> 0
    applyStimulus("rst3", 1'b0, RTYPE, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) applyStimulus("rel240", 1'b1, 9'b0_0001_1111, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) applyStimulus("wrap", 1'b1, RTYPE, 1'b0, 1'b0);
    // relative wrap: 1 + 240 ... from 4095 region
    applyStimulus("rst4", 1'b0, RTYPE, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) applyStimulus("relwrap", 1'b1, 9'b0_0001_1111, 1'b0, 1'b1);

    // halt opcode at PC 5
    applyStimulus("rst5", 1'b0, RTYPE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus("to5", 1'b1, RTYPE, 1'b0, 1'b0);
    applyStimulus("halt", 1'b1, 9'b11111_0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("post_halt", 1'b1, RTYPE, 1'b1, 1'b1);
    applyStimulus("halt_rst", 1'b0, RTYPE, 1'b0, 1'b0);
    applyStimulus("after_rst", 1'b1, RTYPE, 1'b0, 1'b0);

    if (sb.size() != 0) checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
